// File: rtl/cache_pkg.sv
// Shared types and geometry for the MEM-stage cache controller.
package cache_pkg;

  localparam int unsigned ADDR_W   = 19;
  localparam int unsigned TAG_W    = 10;
  localparam int unsigned INDEX_W  = 6;
  localparam int unsigned OFFSET_W = 3;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned BLOCK_W  = 64;
  localparam int unsigned STAT_W   = 16;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_MISS = 2'd1,
    FILL      = 2'd2,
    WRITE     = 2'd3
  } state_e;

  // Offset bit 2 picks the upper word of a 64-bit block.
  function automatic logic [WORD_W-1:0] select_word(input logic [BLOCK_W-1:0] blk,
                                                    input logic               hi);
    return hi ? blk[BLOCK_W-1:WORD_W] : blk[WORD_W-1:0];
  endfunction

endpackage

// File: rtl/cache_stats_counter.sv
// Saturating event counter; only built when CACHE_STATS_EN is defined.
`ifdef CACHE_STATS_EN
module cache_stats_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule
`endif

// File: rtl/cache_controller.sv
// MEM-stage front end for a 2-way cache plus SRAM: same-cycle read hits, block fill
// on read miss, write-through/no-write-allocate stores. CACHE_STATS_EN adds hit/miss counters.
module cache_controller
  import cache_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         mem_address,
  input  logic [WORD_W-1:0]   mem_wdata,
  input  logic                mem_r_en,
  input  logic                mem_w_en,
  output logic [WORD_W-1:0]   mem_rdata,
  output logic                ready,
  output logic [ADDR_W-1:0]   cache_address,
  output logic                cache_read_en,
  output logic                cache_invoke_set,
  output logic                cache_fill_en,
  output logic [BLOCK_W-1:0]  cache_fill_data,
  input  logic [WORD_W-1:0]   cache_rdata,
  input  logic                cache_hit,
  output logic [ADDR_W-1:0]   sram_address,
  output logic [WORD_W-1:0]   sram_wdata,
  output logic                sram_r_en,
  output logic                sram_w_en,
  input  logic [BLOCK_W-1:0]  sram_rdata,
  input  logic                sram_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [STAT_W-1:0]   stat_hits,
  output logic [STAT_W-1:0]   stat_misses
`endif
);

  state_e              state_q, state_d;
  logic [BLOCK_W-1:0]  block_q, block_d;
  logic [WORD_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   addr;
  logic                rd_req;

  // Modulo-2^32 rebase, then truncate: out-of-range addresses simply alias.
  assign addr   = ADDR_W'(mem_address - BASE_ADDR);
  assign rd_req = mem_r_en && !mem_w_en;

  assign cache_address   = addr;
  assign cache_fill_data = block_q;
  assign sram_wdata      = mem_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      block_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      block_q <= block_d;
      rdata_q <= rdata_d;
    end
  end

  // Next state and per-state handshakes; a store wins over a simultaneous load.
  always_comb begin
    state_d          = state_q;
    block_d          = block_q;
    rdata_d          = rdata_q;
    ready            = 1'b0;
    mem_rdata        = rdata_q;
    cache_read_en    = 1'b0;
    cache_invoke_set = 1'b0;
    cache_fill_en    = 1'b0;
    sram_r_en        = 1'b0;
    sram_w_en        = 1'b0;
    sram_address     = addr;

    case (state_q)
      IDLE: begin
        if (mem_w_en) begin
          cache_invoke_set = cache_hit;
          state_d          = WRITE;
        end else if (rd_req) begin
          if (cache_hit) begin
            cache_read_en = 1'b1;
            mem_rdata     = cache_rdata;
            ready         = 1'b1;
          end else begin
            state_d = READ_MISS;
          end
        end else begin
          ready = 1'b1;
        end
      end
      READ_MISS: begin
        sram_r_en    = 1'b1;
        sram_address = {addr[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
        if (sram_ready) begin
          block_d = sram_rdata;
          rdata_d = select_word(sram_rdata, addr[OFFSET_W-1]);
          state_d = FILL;
        end
      end
      FILL: begin
        cache_fill_en = 1'b1;
        ready         = 1'b1;
        state_d       = IDLE;
      end
      WRITE: begin
        sram_w_en = 1'b1;
        if (sram_ready) begin
          ready   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CACHE_STATS_EN
  logic hit_evt, miss_evt;

  assign hit_evt  = (state_q == IDLE) && rd_req && cache_hit;
  assign miss_evt = (state_q == IDLE) && rd_req && !cache_hit;

  cache_stats_counter #(.W(STAT_W)) u_hits (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (hit_evt),
    .count_o (stat_hits)
  );

  cache_stats_counter #(.W(STAT_W)) u_misses (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (miss_evt),
    .count_o (stat_misses)
  );
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: IDLE vector table plus miss/write/reset sequences.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_address, mem_wdata, mem_rdata, cache_rdata, sram_wdata;
  logic        mem_r_en, mem_w_en, ready;
  logic [18:0] cache_address, sram_address;
  logic        cache_read_en, cache_invoke_set, cache_fill_en, cache_hit;
  logic [63:0] cache_fill_data, sram_rdata;
  logic        sram_r_en, sram_w_en, sram_ready;
`ifdef CACHE_STATS_EN
  logic [15:0] stat_hits, stat_misses;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_controller #(.BASE_ADDR(32'd1024)) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_address      (mem_address),
    .mem_wdata        (mem_wdata),
    .mem_r_en         (mem_r_en),
    .mem_w_en         (mem_w_en),
    .mem_rdata        (mem_rdata),
    .ready            (ready),
    .cache_address    (cache_address),
    .cache_read_en    (cache_read_en),
    .cache_invoke_set (cache_invoke_set),
    .cache_fill_en    (cache_fill_en),
    .cache_fill_data  (cache_fill_data),
    .cache_rdata      (cache_rdata),
    .cache_hit        (cache_hit),
    .sram_address     (sram_address),
    .sram_wdata       (sram_wdata),
    .sram_r_en        (sram_r_en),
    .sram_w_en        (sram_w_en),
    .sram_rdata       (sram_rdata),
    .sram_ready       (sram_ready)
`ifdef CACHE_STATS_EN
    ,
    .stat_hits        (stat_hits),
    .stat_misses      (stat_misses)
`endif
  );

  typedef struct {
    string       name;
    logic        r;
    logic        w;
    logic        hit;
    logic [31:0] addr;
    logic [31:0] crd;
    logic        e_ready;
    logic        e_rden;
    logic        e_inv;
    logic [31:0] e_rdata;
    logic [18:0] e_addr;
  } vec_t;

  vec_t vecs[8];

  localparam logic [63:0] BLK = 64'hAAAA0002_BBBB0001;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    mem_address = 32'd1024;
    mem_wdata   = '0;
    mem_r_en    = 1'b0;
    mem_w_en    = 1'b0;
    cache_rdata = '0;
    cache_hit   = 1'b0;
    sram_rdata  = '0;
    sram_ready  = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Read miss with an SRAM that answers on its third requested cycle.
  task automatic read_miss(input string nm, input logic [31:0] a, input logic [31:0] exp_w,
                           input logic [18:0] exp_sa);
    int   low   = 0;
    int   rcyc  = 0;
    int   fills = 0;
    logic done  = 1'b0;
    mem_address = a;
    mem_r_en    = 1'b1;
    cache_hit   = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (sram_r_en) begin
        rcyc++;
        check({nm, "_sram_addr"}, 64'(sram_address), 64'(exp_sa));
        if (rcyc == 3) begin
          sram_ready = 1'b1;
          sram_rdata = BLK;
        end
      end
      #1;
      if (cache_fill_en) begin
        fills++;
        check({nm, "_fill_data"}, cache_fill_data, BLK);
        check({nm, "_rdata"}, 64'(mem_rdata), 64'(exp_w));
      end
      if (ready) done = 1'b1;
      else       low++;
      @(posedge clk); #1;
      sram_ready = 1'b0;
      sram_rdata = '0;
    end
    mem_r_en = 1'b0;
    check({nm, "_done"}, 64'(done), 64'd1);
    check({nm, "_ready_low_cycles"}, 64'(low), 64'd4);
    check({nm, "_fill_pulses"}, 64'(fills), 64'd1);
  endtask

  // Store with SRAM acknowledging after lat WRITE cycles; rd also raises mem_r_en.
  task automatic store(input string nm, input logic [31:0] a, input logic [31:0] wd,
                       input logic hit, input logic rd, input int lat);
    int inv = 0;
    mem_address = a;
    mem_wdata   = wd;
    mem_w_en    = 1'b1;
    mem_r_en    = rd;
    cache_hit   = hit;
    @(negedge clk);
    if (cache_invoke_set) inv++;
    check({nm, "_c0_ready"}, 64'(ready), 64'd0);
    check({nm, "_c0_read_en"}, 64'(cache_read_en), 64'd0);
    check({nm, "_c0_sram_w_en"}, 64'(sram_w_en), 64'd0);
    @(posedge clk); #1;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (cache_invoke_set) inv++;
      check({nm, "_sram_w_en"}, 64'(sram_w_en), 64'd1);
      check({nm, "_sram_wdata"}, 64'(sram_wdata), 64'(wd));
      check({nm, "_read_en"}, 64'(cache_read_en), 64'd0);
      if (k == lat) sram_ready = 1'b1;
      #1;
      check({nm, "_ready"}, 64'(ready), 64'(k == lat));
      @(posedge clk); #1;
      sram_ready = 1'b0;
    end
    mem_w_en = 1'b0;
    mem_r_en = 1'b0;
    @(negedge clk);
    check({nm, "_back_idle_ready"}, 64'(ready), 64'd1);
    check({nm, "_back_idle_w_en"}, 64'(sram_w_en), 64'd0);
    check({nm, "_invoke_cycles"}, 64'(inv), 64'(hit));
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"idle",        1'b0, 1'b0, 1'b0, 32'd1024,       32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         19'h0};
    vecs[1] = '{"rd_hit",      1'b1, 1'b0, 1'b1, 32'd1032,       32'hBBBB0001,  1'b1, 1'b1, 1'b0, 32'hBBBB0001,  19'h8};
    vecs[2] = '{"rd_miss",     1'b1, 1'b0, 1'b0, 32'd1036,       32'h11111111,  1'b0, 1'b0, 1'b0, 32'h0,         19'hC};
    vecs[3] = '{"wr_hit",      1'b0, 1'b1, 1'b1, 32'd1040,       32'h22222222,  1'b0, 1'b0, 1'b1, 32'h0,         19'h10};
    vecs[4] = '{"wr_miss",     1'b0, 1'b1, 1'b0, 32'd1040,       32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         19'h10};
    vecs[5] = '{"rw_hit",      1'b1, 1'b1, 1'b1, 32'd1048,       32'h33333333,  1'b0, 1'b0, 1'b1, 32'h0,         19'h18};
    vecs[6] = '{"wrap_low",    1'b1, 1'b0, 1'b1, 32'h0,          32'h12345678,  1'b1, 1'b1, 1'b0, 32'h12345678,  19'h7FC00};
    vecs[7] = '{"wrap_trunc",  1'b1, 1'b0, 1'b1, 32'h00080404,   32'hCAFEF00D,  1'b1, 1'b1, 1'b0, 32'hCAFEF00D,  19'h4};

    clear_inputs();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_rdata", 64'(mem_rdata), 64'd0);
    check("rst_sram_r_en", 64'(sram_r_en), 64'd0);
    check("rst_sram_w_en", 64'(sram_w_en), 64'd0);
    check("rst_fill_en", 64'(cache_fill_en), 64'd0);
    check("rst_invoke", 64'(cache_invoke_set), 64'd0);

    // IDLE-cycle decode table, each vector from a fresh reset
    foreach (vecs[i]) begin
      do_reset();
      mem_r_en    = vecs[i].r;
      mem_w_en    = vecs[i].w;
      cache_hit   = vecs[i].hit;
      mem_address = vecs[i].addr;
      cache_rdata = vecs[i].crd;
      @(negedge clk);
      check({vecs[i].name, "_ready"}, 64'(ready), 64'(vecs[i].e_ready));
      check({vecs[i].name, "_read_en"}, 64'(cache_read_en), 64'(vecs[i].e_rden));
      check({vecs[i].name, "_invoke"}, 64'(cache_invoke_set), 64'(vecs[i].e_inv));
      check({vecs[i].name, "_rdata"}, 64'(mem_rdata), 64'(vecs[i].e_rdata));
      check({vecs[i].name, "_cache_addr"}, 64'(cache_address), 64'(vecs[i].e_addr));
      check({vecs[i].name, "_sram_addr"}, 64'(sram_address), 64'(vecs[i].e_addr));
      check({vecs[i].name, "_sram_en"}, 64'({sram_r_en, sram_w_en, cache_fill_en}), 64'd0);
    end
    do_reset();

    // Miss then hit on the low word, then a miss on the high word
    read_miss("miss_lo", 32'd1032, 32'hBBBB0001, 19'd8);
    mem_address = 32'd1032;
    mem_r_en    = 1'b1;
    cache_hit   = 1'b1;
    cache_rdata = 32'hBBBB0001;
    @(negedge clk);
    check("hit_after_fill_ready", 64'(ready), 64'd1);
    check("hit_after_fill_rdata", 64'(mem_rdata), 64'hBBBB0001);
    check("hit_after_fill_sram_r_en", 64'(sram_r_en), 64'd0);
    @(posedge clk); #1;
    clear_inputs();
    read_miss("miss_hi", 32'd1036, 32'hAAAA0002, 19'd8);

    // Stores: hit, miss, and load+store together
    store("st_hit", 32'd1040, 32'hDEADBEEF, 1'b1, 1'b0, 3);
    store("st_miss", 32'd1044, 32'h0BADF00D, 1'b0, 1'b0, 2);
    store("st_rw", 32'd1048, 32'h5A5A5A5A, 1'b1, 1'b1, 1);

    // Reset in READ_MISS, even with SRAM answering that cycle
    mem_address = 32'd1056;
    mem_r_en    = 1'b1;
    cache_hit   = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rmid_sram_r_en_before", 64'(sram_r_en), 64'd1);
    rst        = 1'b1;
    sram_ready = 1'b1;
    sram_rdata = BLK;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    check("rmid_sram_r_en", 64'(sram_r_en), 64'd0);
    check("rmid_ready", 64'(ready), 64'd1);
    check("rmid_fill_en", 64'(cache_fill_en), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rmid_fill_en_later", 64'(cache_fill_en), 64'd0);

    // Stray sram_ready in IDLE
    sram_ready = 1'b1;
    sram_rdata = BLK;
    @(negedge clk);
    check("stray_ready", 64'(ready), 64'd1);
    @(posedge clk); #1;
    sram_ready = 1'b0;
    @(negedge clk);
    check("stray_fill_en", 64'(cache_fill_en), 64'd0);
    check("stray_sram_en", 64'({sram_r_en, sram_w_en}), 64'd0);
    check("stray_rdata_kept", 64'(mem_rdata), 64'd0);

`ifdef CACHE_STATS_EN
    do_reset();
    @(negedge clk);
    check("stats_rst_hits", 64'(stat_hits), 64'd0);
    check("stats_rst_misses", 64'(stat_misses), 64'd0);
    @(posedge clk); #1;
    mem_address = 32'd1032;
    mem_r_en    = 1'b1;
    cache_hit   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    clear_inputs();
    read_miss("st_m1", 32'd1032, 32'hBBBB0001, 19'd8);
    read_miss("st_m2", 32'd1036, 32'hAAAA0002, 19'd8);
    store("st_w", 32'd1040, 32'h1, 1'b1, 1'b0, 1);
    @(negedge clk);
    check("stats_hits", 64'(stat_hits), 64'd3);
    check("stats_misses", 64'(stat_misses), 64'd2);
    @(posedge clk); #1;
    mem_r_en  = 1'b1;
    cache_hit = 1'b1;
    repeat (65532) @(posedge clk);
    #1;
    mem_r_en = 1'b0;
    @(negedge clk);
    check("stats_hits_full", 64'(stat_hits), 64'hFFFF);
    mem_r_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mem_r_en = 1'b0;
    @(negedge clk);
    check("stats_hits_sat", 64'(stat_hits), 64'hFFFF);
    check("stats_misses_kept", 64'(stat_misses), 64'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Sits between the MEM stage and the 2-way set-associative data cache / SRAM controller pair.
- Translates MEM-stage word accesses into 19-bit cache addresses and serves read hits in the same cycle.
- On a read miss, fetches the 64-bit block from SRAM, fills the cache and returns the selected word.
- Writes are write-through, no-write-allocate; a matching cache line is invalidated. `ready` stalls the pipeline while SRAM is busy.

Parameters:
- BASE_ADDR, 1024: data-memory base; subtracted from the MEM address before translation.
- ADDR_W, 19: cache/SRAM byte-address width. Layout is tag[18:9], index[8:3], offset[2:0].

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_address  in  32  byte address from MEM stage
- mem_wdata  in  32  store data
- mem_r_en  in  1  load request
- mem_w_en  in  1  store request
- mem_rdata  out  32  load result
- ready  out  1  1 = access complete or idle; 0 = stall pipeline
- cache_address  out  19  address to cache
- cache_read_en  out  1  cache lookup/LRU update
- cache_invoke_set  out  1  invalidate hitting line
- cache_fill_en  out  1  write block into LRU way
- cache_fill_data  out  64  block {word1, word0}
- cache_rdata  in  32  cache read word
- cache_hit  in  1  cache hit
- sram_address  out  19  SRAM byte address
- sram_wdata  out  32  SRAM store data
- sram_r_en  out  1  SRAM block read
- sram_w_en  out  1  SRAM word write
- sram_rdata  in  64  SRAM block data
- sram_ready  in  1  SRAM op done (1-cycle pulse)

Behaviour:
- Address: `cache_address = sram_address = (mem_address - BASE_ADDR)[18:0]`; for block reads, `sram_address[2:0]` is forced to 0.
- Word select: offset[2] = 0 selects the low 32 bits of a block, 1 selects the high 32 bits.
- Reset: state = IDLE; `sram_r_en`, `sram_w_en`, `cache_fill_en`, `cache_invoke_set` = 0; `mem_rdata` = 0; `ready` = 1.
- `rst` asserted in any state aborts the operation and returns to IDLE next edge; no fill or invalidate is issued.
- States: IDLE, READ_MISS, FILL, WRITE.
- IDLE, no request: `ready` = 1; all enables 0.
- IDLE, `mem_r_en` with `cache_hit` = 1:
  - `cache_read_en` = 1; `mem_rdata` = `cache_rdata` combinationally; `ready` = 1 in the same cycle (0-cycle latency).
- IDLE, `mem_r_en` with `cache_hit` = 0:
  - `ready` = 0; go to READ_MISS.
  - READ_MISS: `sram_r_en` = 1 until `sram_ready`; on `sram_ready`, latch `sram_rdata` into a block register and go to FILL.
  - FILL (one cycle): `cache_fill_en` = 1 with the latched block; `mem_rdata` = selected word, registered; `ready` = 1; go to IDLE.
  - Miss latency = SRAM latency + 1 cycle.
- IDLE, `mem_w_en`:
  - `ready` = 0; if `cache_hit`, `cache_invoke_set` = 1 for exactly this cycle; go to WRITE.
  - WRITE: `sram_w_en` = 1 and `sram_wdata` = `mem_wdata` until `sram_ready`.
  - `ready` = 1 in the cycle `sram_ready` is high; go to IDLE.
- `mem_r_en` and `mem_w_en` both high: treated as a write.
- The pipeline holds `mem_*` inputs stable while `ready` = 0; the controller does not re-sample them after IDLE.
- A `sram_ready` pulse while in IDLE is ignored.
- Address wrap: the subtraction is modulo 2^32 and then truncated to 19 bits; there is no range check.

Optional Feature:
- CACHE_STATS_EN defined: adds outputs `stat_hits[15:0]` and `stat_misses[15:0]`.
  - `stat_hits` increments on an IDLE read hit; `stat_misses` increments on IDLE→READ_MISS.
  - Both saturate at 16'hFFFF, clear on `rst`, and ignore writes.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package `cache_pkg`:
  - state enum {IDLE, READ_MISS, FILL, WRITE}
  - ADDR_W, TAG_W = 10, INDEX_W = 6, OFFSET_W = 3, BLOCK_W = 64, default BASE_ADDR
- FSM and datapath stay in one module.
- Sub-module `cache_stats_counter` (one saturating counter, instantiated twice) is natural under CACHE_STATS_EN.

Test Plan:
1. Read miss, then hit:
   - `mem_r_en`, `mem_address` = 1024+8, `cache_hit` = 0, SRAM returns 64'hAAAA0002_BBBB0001 after 3 cycles.
   - Expect `sram_address` = 8, `ready` low 4 cycles, FILL pulse carrying that block, `mem_rdata` = 32'hBBBB0001.
   - Repeat with `cache_hit` = 1, `cache_rdata` = 32'hBBBB0001: expect `ready` = 1 and data in the same cycle.
2. Upper-word select: `mem_address` = 1024+12, miss, same SRAM data → `mem_rdata` = 32'hAAAA0002; `sram_address` = 8.
3. Store to a hitting line:
   - `mem_w_en`, `mem_wdata` = 32'hDEADBEEF, `cache_hit` = 1.
   - Expect `cache_invoke_set` high for 1 cycle, then `sram_w_en` held with the same data until `sram_ready`, `ready` = 1 on that cycle.
   - Store to a miss: `cache_invoke_set` never asserted.
4. Reset mid-miss: assert `rst` during READ_MISS → next cycle IDLE, `sram_r_en` = 0, `ready` = 1, no `cache_fill_en` pulse.
5. Simultaneous `mem_r_en` and `mem_w_en` with `cache_hit` = 1 → write path taken (`invoke_set` then WRITE); `cache_read_en` stays 0.
6. CACHE_STATS_EN: 3 hits, 2 misses, 1 write → `stat_hits` = 3, `stat_misses` = 2; preload near 16'hFFFF, then 2 hits → holds at 16'hFFFF.
